// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet source for the router input port
//
// Buffers one packet's payload from an upstream byte stream, then drives
// header, payload and parity onto the router's data_in/pkt_valid/busy
// interface with no bubbles. Parity is the XOR of header and payload, with
// optional corruption by ERR_MASK to exercise the router's error path.
//
// Ports:
//   clock        in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   start        in   packet request, sampled only in IDLE
//   dest_addr    in   [1:0] destination port 0..2 (3 illegal)
//   payload_len  in   [5:0] payload byte count 1..63 (0 illegal)
//   inject_err   in   corrupt this packet's parity byte (sampled with start)
//   pl_data      in   [7:0] upstream payload byte
//   pl_valid     in   upstream byte valid
//   pl_ready     out  upstream ready, high only while loading
//   busy         in   router busy; holds the presented byte
//   data_out     out  [7:0] to router data_in
//   pkt_valid    out  to router pkt_valid (header and payload only)
//   tx_active    out  high whenever not idle
//   done         out  one-cycle pulse after the parity byte is accepted
//   cfg_err      out  one-cycle pulse after a start request is rejected

module router_pkt_tx #(
  parameter int         IFG      = 4,
  parameter logic [7:0] ERR_MASK = 8'h01
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       inject_err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_PARITY,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_INIT = 4'(IFG - 1);

  state_t     state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic       inj_q, inj_d;
  logic [7:0] par_q, par_d;
  logic [5:0] wr_idx_q, wr_idx_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  // Set while the header (not a payload byte) is the byte on data_out.
  logic       hdr_phase_q, hdr_phase_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] data_out_q, data_out_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       done_q, done_d;
  logic       cfg_err_q, cfg_err_d;

  logic [7:0] pl_buf_q [0:63];
  logic       buf_we;

  logic [5:0] len_w;
  assign len_w = hdr_q[7:2];

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    inj_d       = inj_q;
    par_d       = par_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    hdr_phase_d = hdr_phase_q;
    gap_d       = gap_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dest_addr != 2'd3 && payload_len != 6'd0) begin
            hdr_d    = {payload_len, dest_addr};
            inj_d    = inject_err;
            par_d    = {payload_len, dest_addr};
            wr_idx_d = 6'd0;
            state_d  = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (pl_valid) begin
          buf_we   = 1'b1;
          par_d    = par_q ^ pl_data;
          wr_idx_d = wr_idx_q + 6'd1;
          if (wr_idx_q == len_w - 6'd1) begin
            data_out_d  = hdr_q;
            pkt_valid_d = 1'b1;
            rd_idx_d    = 6'd0;
            hdr_phase_d = 1'b1;
            state_d     = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (!busy) begin
          if (hdr_phase_q) begin
            data_out_d  = pl_buf_q[0];
            hdr_phase_d = 1'b0;
            rd_idx_d    = 6'd0;
          end else if (rd_idx_q == len_w - 6'd1) begin
            // Accumulator already holds header ^ all payload bytes.
            data_out_d  = par_q ^ (inj_q ? ERR_MASK : 8'h00);
            pkt_valid_d = 1'b0;
            state_d     = S_PARITY;
          end else begin
            data_out_d = pl_buf_q[rd_idx_q + 6'd1];
            rd_idx_d   = rd_idx_q + 6'd1;
          end
        end
      end

      S_PARITY: begin
        if (!busy) begin
          done_d     = 1'b1;
          data_out_d = 8'h00;
          gap_d      = GAP_INIT;
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hdr_q       <= 8'h00;
      inj_q       <= 1'b0;
      par_q       <= 8'h00;
      wr_idx_q    <= 6'd0;
      rd_idx_q    <= 6'd0;
      hdr_phase_q <= 1'b0;
      gap_q       <= 4'd0;
      data_out_q  <= 8'h00;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      inj_q       <= inj_d;
      par_q       <= par_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      hdr_phase_q <= hdr_phase_d;
      gap_q       <= gap_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Payload storage is not reset; contents are only read after being written.
  always_ff @(posedge clock) begin
    if (resetn && buf_we) begin
      pl_buf_q[wr_idx_q] <= pl_data;
    end
  end

  assign pl_ready  = (state_q == S_LOAD);
  assign tx_active = (state_q != S_IDLE);
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
